// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  localparam int ERR_VAL_MISMATCH = 0;
  localparam int ERR_OVERRUN      = 1;
  localparam int ERR_SATURATE     = 2;
  localparam int ERR_BITS         = 3;

  // Signed saturation bound for a two's complement value of the given width.
  function automatic logic signed [63:0] sat_limit(input int unsigned width, input logic want_max);
    logic signed [63:0] one;
    one = 64'sd1;
    if (want_max) return (one <<< (width - 1)) - one;
    else          return -(one <<< (width - 1));
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One kernel lane: sign-extends a psum, adds it to the lane accumulator with
// saturation, and holds the running sum.
module psum_acc_lane
  import psum_acc_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] psum,
  input  logic                 add_en,
  input  logic                 clr,
  output logic [ACC_WIDTH-1:0] acc,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sat
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_limit(ACC_WIDTH, 1'b1));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_limit(ACC_WIDTH, 1'b0));

  logic [ACC_WIDTH:0] wide;

  // One guard bit detects signed overflow; clamp toward the overflow direction.
  always_comb begin
    wide = {acc[ACC_WIDTH-1], acc}
         + {{(ACC_WIDTH + 1 - BIT_WIDTH){psum[BIT_WIDTH-1]}}, psum};
    sat  = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    if (!sat)                sum = wide[ACC_WIDTH-1:0];
    else if (wide[ACC_WIDTH]) sum = ACC_MIN;
    else                     sum = ACC_MAX;
  end

  // Accumulator register; clear wins over add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc <= '0;
    else if (clr)    acc <= '0;
    else if (add_en) acc <= sum;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates NUM_KERNEL signed psum lanes over a configurable number of beats
// and presents finished sums through a valid/ready output register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no group open, count 0; a full beat opens a group
// ST_ACCUM | group open, accumulating until the count reaches N
// ST_HOLD  | finished sum parked in the accumulators, output still full
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int PASS_WIDTH = 8,
  parameter int REG_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
  input  logic [NUM_KERNEL-1:0]           i_psum_val,
  input  logic [PASS_WIDTH-1:0]           cfg_num_pass,
  input  logic                            i_clear,
  output logic [ACC_WIDTH*NUM_KERNEL-1:0] o_acc,
  output logic                            o_acc_val,
  input  logic                            i_acc_rdy,
  output logic [PASS_WIDTH-1:0]           o_pass_cnt,
  output logic                            o_busy,
  output logic [REG_WIDTH-1:0]            err_status
);

  acc_state_e state, state_nxt;

  logic [PASS_WIDTH-1:0] pass_n, pass_n_nxt, cnt_nxt, n_cfg, n_now;
  logic                  beat_full, beat_part, accept, last, out_free, xfer;
  logic                  lane_add, lane_clr, load_sum, load_acc;
  logic [NUM_KERNEL-1:0] sat_vec;
  logic [ERR_BITS-1:0]   err_flags, err_set;

  logic [ACC_WIDTH*NUM_KERNEL-1:0] acc_all, sum_all;

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    psum_acc_lane #(
      .BIT_WIDTH(BIT_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .psum  (i_psum[BIT_WIDTH*k +: BIT_WIDTH]),
      .add_en(lane_add),
      .clr   (lane_clr),
      .acc   (acc_all[ACC_WIDTH*k +: ACC_WIDTH]),
      .sum   (sum_all[ACC_WIDTH*k +: ACC_WIDTH]),
      .sat   (sat_vec[k])
    );
  end

  // Beat qualification and last-beat detection; N is live from cfg only while idle.
  always_comb begin
    beat_full = &i_psum_val;
    beat_part = (|i_psum_val) && !beat_full;
    accept    = beat_full && (state != ST_HOLD);
    n_cfg     = (cfg_num_pass == '0) ? PASS_WIDTH'(1) : cfg_num_pass;
    n_now     = (state == ST_IDLE) ? n_cfg : pass_n;
    last      = accept && ((o_pass_cnt + PASS_WIDTH'(1)) == n_now);
    out_free  = !o_acc_val || i_acc_rdy;
    xfer      = o_acc_val && i_acc_rdy;
  end

  // Next-state and datapath control; i_clear overrides everything.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = o_pass_cnt;
    pass_n_nxt = pass_n;
    lane_add   = 1'b0;
    lane_clr   = 1'b0;
    load_sum   = 1'b0;
    load_acc   = 1'b0;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (state == ST_IDLE) pass_n_nxt = n_cfg;
          if (last && out_free) begin
            load_sum  = 1'b1;
            lane_clr  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            lane_add  = 1'b1;
            cnt_nxt   = o_pass_cnt + PASS_WIDTH'(1);
            state_nxt = last ? ST_HOLD : ST_ACCUM;
          end
        end
      end
      ST_HOLD: begin
        if (xfer) begin
          load_acc  = 1'b1;
          lane_clr  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (i_clear) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      pass_n_nxt = '0;
      lane_add   = 1'b0;
      lane_clr   = 1'b1;
      load_sum   = 1'b0;
      load_acc   = 1'b0;
    end
  end

  // Error sources for this cycle; overrun counts any activity while parked.
  always_comb begin
    err_set                   = '0;
    err_set[ERR_VAL_MISMATCH] = beat_part;
    err_set[ERR_OVERRUN]      = (state == ST_HOLD) && (|i_psum_val);
    err_set[ERR_SATURATE]     = accept && (|sat_vec);
  end

  // State, counters, output register and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      o_pass_cnt <= '0;
      pass_n     <= '0;
      o_acc      <= '0;
      o_acc_val  <= 1'b0;
      err_flags  <= '0;
    end else begin
      state      <= state_nxt;
      o_pass_cnt <= cnt_nxt;
      pass_n     <= pass_n_nxt;
      if (i_clear) begin
        o_acc     <= '0;
        o_acc_val <= 1'b0;
      end else if (load_sum) begin
        o_acc     <= sum_all;
        o_acc_val <= 1'b1;
      end else if (load_acc) begin
        o_acc     <= acc_all;
        o_acc_val <= 1'b1;
      end else if (xfer) begin
        o_acc_val <= 1'b0;
      end
      err_flags <= i_clear ? '0 : (err_flags | err_set);
    end
  end

  assign o_busy     = (state != ST_IDLE) || o_acc_val;
  assign err_status = {{(REG_WIDTH - ERR_BITS){1'b0}}, err_flags};

endmodule
